// File: rtl/xex_pkg.sv
// Shared constants and types for the XEX sector streamer: engine mode codes and the job state machine.
package xex_pkg;

    localparam int BLK_W = 128;

    localparam logic [1:0] XEX_IDLE = 2'b00;
    localparam logic [1:0] XEX_ENC  = 2'b10;
    localparam logic [1:0] XEX_DEC  = 2'b11;

    typedef enum logic [1:0] {
        XS_IDLE  = 2'd0,
        XS_RUN   = 2'd1,
        XS_DRAIN = 2'd2,
        XS_DONE  = 2'd3
    } xs_state_t;

    function automatic logic [1:0] cmd_mode(input logic dec);
        logic [1:0] m;
        if (dec) begin
            m = XEX_DEC;
        end else begin
            m = XEX_ENC;
        end
        return m;
    endfunction

endpackage

// File: rtl/xex_out_fifo.sv
// Result FIFO between the engine and the downstream port; the head entry is presented combinationally.
module xex_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1'b1);
        end
        return r;
    endfunction

    assign empty = (count_q == {CNT_W{1'b0}});
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1'b1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/xex_sector_streamer.sv
// Streams one sector job of 1..256 blocks into the XEX engine and returns its results downstream.
// Issue is credit-limited so every engine result always has a FIFO slot waiting for it.
module xex_sector_streamer #(
    parameter int BLK_W     = 128,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dec,
    input  logic [BLK_W-1:0] cmd_sector,
    input  logic [7:0]       cmd_nblk,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_last,
    output logic             done,
    output logic             err,
    output logic             in_rdy,
    output logic [1:0]       mode,
    output logic [BLK_W-1:0] sector,
    output logic [BLK_W-1:0] data_in,
    input  logic             busy,
    input  logic             out_rdy,
    input  logic [BLK_W-1:0] data_out
);
    import xex_pkg::*;

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    xs_state_t        state_q;
    xs_state_t        state_d;
    logic [BLK_W-1:0] sector_q;
    logic [BLK_W-1:0] sector_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [8:0]       nblk_q;
    logic [8:0]       nblk_d;
    logic [8:0]       issued_q;
    logic [8:0]       issued_d;
    logic [8:0]       popped_q;
    logic [8:0]       popped_d;
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] outst_d;
    logic             err_q;
    logic             err_d;

    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic             credit;
    logic             cmd_take;
    logic             issue;
    logic             result_ok;
    logic             result_bad;

    xex_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (BLK_W),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (data_out),
        .pop   (fifo_pop),
        .rdata (m_data),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= XS_IDLE;
            sector_q <= {BLK_W{1'b0}};
            mode_q   <= XEX_IDLE;
            nblk_q   <= 9'd0;
            issued_q <= 9'd0;
            popped_q <= 9'd0;
            outst_q  <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            mode_q   <= mode_d;
            nblk_q   <= nblk_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            XS_IDLE: begin
                if (cmd_valid) state_d = XS_RUN;
                else           state_d = XS_IDLE;
            end
            XS_RUN: begin
                if (issue && ((issued_q + 9'd1) == nblk_q)) state_d = XS_DRAIN;
                else                                         state_d = XS_RUN;
            end
            XS_DRAIN: begin
                if (popped_d == nblk_q) state_d = XS_DONE;
                else                    state_d = XS_DRAIN;
            end
            XS_DONE:  state_d = XS_IDLE;
            default:  state_d = XS_IDLE;
        endcase
    end

    // Moore/handshake outputs; the engine side is combinational so issue costs no cycle.
    always_comb begin
        credit    = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < SUM_W'(OUT_DEPTH);
        cmd_ready = (state_q == XS_IDLE);
        done      = (state_q == XS_DONE);
        if ((state_q == XS_RUN) || (state_q == XS_DRAIN)) begin
            mode = mode_q;
        end else begin
            mode = XEX_IDLE;
        end
        if (state_q == XS_RUN) begin
            in_rdy = s_valid & credit & (issued_q < nblk_q);
        end else begin
            in_rdy = 1'b0;
        end
        s_ready = in_rdy & ~busy;
        data_in = s_data;
        sector  = sector_q;
        m_valid = ~fifo_empty;
        m_last  = m_valid & (popped_q == (nblk_q - 9'd1));
        err     = err_q;
    end

    // Job bookkeeping: a result with nothing outstanding is flagged and dropped.
    always_comb begin
        cmd_take   = (state_q == XS_IDLE) & cmd_valid;
        issue      = s_ready;
        result_ok  = out_rdy & (outst_q != {CNT_W{1'b0}});
        result_bad = out_rdy & (outst_q == {CNT_W{1'b0}});
        fifo_push  = result_ok & ~fifo_full;
        fifo_pop   = m_valid & m_ready;
        sector_d   = sector_q;
        mode_d     = mode_q;
        nblk_d     = nblk_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        outst_d    = outst_q;
        err_d      = err_q | result_bad;
        if (cmd_take) begin
            sector_d = cmd_sector;
            mode_d   = cmd_mode(cmd_dec);
            if (cmd_nblk == 8'd0) nblk_d = 9'd256;
            else                  nblk_d = {1'b0, cmd_nblk};
            issued_d = 9'd0;
            popped_d = 9'd0;
            outst_d  = {CNT_W{1'b0}};
        end else begin
            if (issue) issued_d = issued_q + 9'd1;
            else       issued_d = issued_q;
            if (fifo_pop) popped_d = popped_q + 9'd1;
            else          popped_d = popped_q;
            outst_d = outst_q + {{(CNT_W-1){1'b0}}, issue} - {{(CNT_W-1){1'b0}}, result_ok};
        end
    end

endmodule

// File: tb/tb_xex_sector_streamer.sv
// Directed bench for xex_sector_streamer with a simple XOR engine model and an in-order scoreboard.
module tb_xex_sector_streamer;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dec;
    logic [127:0] cmd_sector;
    logic [7:0]   cmd_nblk;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic         done;
    logic         err;
    logic         in_rdy;
    logic [1:0]   mode;
    logic [127:0] sector;
    logic [127:0] data_in;
    logic         busy;
    logic         out_rdy;
    logic [127:0] data_out;

    logic         eng_busy;
    logic         eng_ordy;
    logic [127:0] eng_res;
    int           eng_cnt;
    int           eng_lat = 14;
    logic         spur;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] blk [256];

    xex_sector_streamer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dec(cmd_dec),
        .cmd_sector(cmd_sector), .cmd_nblk(cmd_nblk),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .err(err),
        .in_rdy(in_rdy), .mode(mode), .sector(sector), .data_in(data_in),
        .busy(busy), .out_rdy(out_rdy), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign busy    = eng_busy;
    assign out_rdy = eng_ordy | spur;

    // Engine model: one block at a time, result = data ^ sector with the mode in the low bits.
    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_ordy <= 1'b0;
            eng_cnt  <= 0;
            data_out <= 128'd0;
        end else begin
            eng_ordy <= 1'b0;
            if (!eng_busy) begin
                if (in_rdy) begin
                    eng_busy <= 1'b1;
                    eng_cnt  <= eng_lat - 1;
                    eng_res  <= data_in ^ sector ^ {126'd0, mode};
                end
            end else if (eng_cnt == 0) begin
                eng_busy <= 1'b0;
                eng_ordy <= 1'b1;
                data_out <= eng_res;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic dec_i, input logic [127:0] sec_i, input logic [7:0] nblk_i,
                           input int stall_i, input bit gaps_i, input int abort_i);
        int n, sent, got, cyc, stall_issues, last_pop;
        bit fin, pend_push;
        logic [1:0] md;
        logic [127:0] exp;
        n = (nblk_i == 8'd0) ? 256 : int'(nblk_i);
        sent = 0; got = 0; cyc = 0; stall_issues = 0; last_pop = -10;
        fin = 1'b0; pend_push = 1'b0;
        md = dec_i ? 2'b11 : 2'b10;
        @(posedge clk); #1;
        s_valid = 1'b0; m_ready = 1'b1;
        cmd_valid = 1'b1; cmd_dec = dec_i; cmd_sector = sec_i; cmd_nblk = nblk_i;
        @(negedge clk);
        chk("cmd_ready_idle", 128'(cmd_ready), 128'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_sector = ~sec_i;
        while (!fin && cyc < n * 20 + stall_i + 100) begin
            if (abort_i != 0 && sent == abort_i) break;
            s_valid = gaps_i ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = blk[sent % 256];
            m_ready = (cyc < stall_i) ? 1'b0 : (gaps_i ? ($urandom_range(0, 3) != 0) : 1'b1);
            cmd_valid = (gaps_i && cyc == 3);
            cmd_dec   = ~dec_i;
            @(negedge clk);
            if (pend_push) chk("result_latency", 128'(m_valid), 128'd1);
            pend_push = out_rdy;
            chk("s_ready_rule", 128'(s_ready), 128'(in_rdy & ~busy));
            chk("data_in_pass", data_in, s_data);
            if (gaps_i && cyc == 4) begin
                chk("cmd_ignored_sector", sector, sec_i);
                chk("cmd_ignored_mode", 128'(mode), 128'(md));
            end
            if (s_ready) begin
                chk("issue_bound", 128'(sent < n), 128'd1);
                if (cyc < stall_i) stall_issues++;
                sent++;
            end
            if (m_valid && m_ready) begin
                exp = blk[got % 256] ^ sec_i ^ {126'd0, md};
                chk("m_data", m_data, exp);
                chk("m_last", 128'(m_last), 128'(got == n - 1));
                got++;
                last_pop = cyc;
            end
            if (done) begin
                fin = 1'b1;
                chk("done_timing", 128'(cyc), 128'(last_pop + 1));
                chk("done_mode", 128'(mode), 128'd0);
                chk("done_count", 128'(got), 128'(n));
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0; cmd_valid = 1'b0;
        if (abort_i != 0) begin
            rst = 1'b1; m_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("abort_cmd_ready", 128'(cmd_ready), 128'd1);
            chk("abort_m_valid", 128'(m_valid), 128'd0);
            chk("abort_mode", 128'(mode), 128'd0);
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk("abort_fifo_empty", 128'(m_valid), 128'd0);
            return;
        end
        chk("job_finished", 128'(fin), 128'd1);
        chk("issued_total", 128'(sent), 128'(n));
        chk("err_clear", 128'(err), 128'd0);
        if (stall_i > 0) chk("stall_issues", 128'(stall_issues), 128'd4);
        @(negedge clk);
        chk("idle_after_done", 128'({cmd_ready, mode}), 128'({1'b1, 2'b00}));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst = 1'b1; spur = 1'b0;
        cmd_valid = 1'b0; cmd_dec = 1'b0; cmd_sector = 128'd0; cmd_nblk = 8'd0;
        s_valid = 1'b0; s_data = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk("rst_outputs", 128'({s_ready, in_rdy, m_valid, m_last, done, err}), 128'd0);
        chk("rst_mode", 128'(mode), 128'd0);
        chk("rst_sector", sector, 128'd0);
        chk("rst_data_in", data_in, s_data);

        eng_lat = 14;
        run_job(1'b0, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 8'd1, 0, 1'b0, 0);
        run_job(1'b0, 128'h0f0f_0f0f_f0f0_f0f0_1234_5678_9abc_def0, 8'd16, 100, 1'b0, 0);
        eng_lat = 3;
        run_job(1'b1, 128'hcafe_f00d_8badf00d_0000_0000_a5a5_5a5a, 8'd20, 0, 1'b1, 0);
        eng_lat = 14;
        run_job(1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'd32, 0, 1'b0, 5);
        run_job(1'b1, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 8'd3, 0, 1'b0, 0);
        run_job(1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_0042, 8'd0, 0, 1'b0, 0);

        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_err_set", 128'(err), 128'd1);
        chk("spur_fifo_empty", 128'(m_valid), 128'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("spur_err_sticky", 128'(err), 128'd1);
        chk("spur_idle", 128'(cmd_ready), 128'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("spur_err_rst", 128'(err), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
